twos_complement_adder: RTL and testbench
========================================

// Module: twos_complement_adder
// PURPOSE
//   Registered WIDTH-bit two's-complement adder with carry-in: sum = x + y + c_in.
//   Provides a carry-out, a signed-overflow flag and a one-cycle valid pipeline.
//   Leaf arithmetic block for datapaths that feed ALU/accumulator stages.
// PARAMETERS
//   WIDTH  4  operand and result width in bits (legal range 2..64)
// PORTS
//   clk       input   1      single clock; all state updates on the rising edge
//   rst       input   1      synchronous reset, active-high
//   in_valid  input   1      x/y/c_in are valid this cycle
//   x         input   WIDTH  operand A (two's complement, also usable unsigned)
//   y         input   WIDTH  operand B
//   c_in      input   1      carry-in, weight 1
//   out_valid output  1      sum/c_out/ovf hold a new result
//   sum       output  WIDTH  low WIDTH bits of x+y+c_in
//   c_out     output  1      unsigned carry out of bit WIDTH-1
//   ovf       output  1      signed overflow: x[MSB]==y[MSB] && sum[MSB]!=x[MSB]
// BEHAVIOUR
//   - Reset: one clock, synchronous, active-high; rst=1 at a rising edge clears
//     sum, c_out, ovf and out_valid to 0. rst has priority over in_valid.
//   - Latency: exactly 1 cycle. On an edge with in_valid=1, the result of that
//     cycle's x, y, c_in is registered and out_valid=1 on the next cycle.
//   - in_valid=0: out_valid goes to 0 next cycle; sum/c_out/ovf hold last values.
//   - Back-to-back: one new operation per cycle, no stalls; no backpressure input.
//   - Arithmetic: full = {1'b0,x} + {1'b0,y} + c_in (WIDTH+1 bits);
//     sum = full[WIDTH-1:0], c_out = full[WIDTH].
//   - Wrap-around: unsigned overflow wraps modulo 2^WIDTH, reported by c_out only.
//   - ovf computed from the operand and sum MSBs; independent of c_out.
//   - Reset mid-stream: any in-flight result is discarded; first valid output
//     after reset release appears one cycle after the first in_valid=1.
//   - X/Z on operands while in_valid=0 must not propagate into the registers.
// CONFIGURATION
//   Macro TCA_SATURATE_EN:
//   - defined: when ovf would be 1, sum is clamped to the signed limit (0111..1
//     if operands positive, 1000..0 if negative); ovf still reports 1; c_out
//     unchanged (raw carry).
//   - undefined (default): sum is the raw wrapped value; no clamp logic built.
// STRUCTURE
//   - Package tca_pkg: TCA_DEFAULT_WIDTH = 4, signed min/max constant functions
//     for the saturation limits.
//   - Sub-module tca_full_adder (a, b, cin -> s, cout); WIDTH instances chained
//     as a ripple adder via generate; top level adds the ovf/saturate logic and
//     output registers.
// TESTING
//   - x=5, y=3, c_in=0, in_valid=1 -> next cycle: sum=8, c_out=0, ovf=1,
//     out_valid=1 (TCA_SATURATE_EN: sum=7).
//   - x=5, y=3, c_in=1 -> sum=9, c_out=0, ovf=1; x=7, y=2, c_in=1 -> sum=10,
//     c_out=0, ovf=1.
//   - x=15, y=1, c_in=0 -> sum=0, c_out=1, ovf=0 (wrap: -1+1=0).
//   - x=8, y=8, c_in=0 -> sum=0, c_out=1, ovf=1 (TCA_SATURATE_EN: sum=8 = -8).
//   - Stream 3 ops on consecutive cycles, then in_valid=0 -> 3 consecutive
//     results, then out_valid=0 with sum held.
//   - Assert rst for 1 cycle while in_valid=1 -> all outputs 0 next cycle,
//     no stale result afterwards.

Source files
------------

// File: rtl/tca_pkg.sv
// -----------------------------------------------------------------------------
// tca_pkg
//   Shared constants and helpers for the twos_complement_adder slice.
//   - TCA_DEFAULT_WIDTH : default operand/result width
//   - tca_signed_max()  : bit pattern 0111..1 for a given width (zero-extended)
//   - tca_signed_min()  : bit pattern 1000..0 for a given width (zero-extended)
//   The helpers are constant functions so they can size localparams; they
//   return 64 bits because that is the widest legal adder.
// -----------------------------------------------------------------------------
package tca_pkg;

  localparam int TCA_DEFAULT_WIDTH = 4;

  function automatic logic [63:0] tca_signed_max(input int width);
    tca_signed_max = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] tca_signed_min(input int width);
    tca_signed_min = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/tca_full_adder.sv
// -----------------------------------------------------------------------------
// tca_full_adder
//   One-bit full adder, the ripple cell of twos_complement_adder.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     s     : sum bit   (a ^ b ^ cin)
//     cout  : carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module tca_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/twos_complement_adder.sv
// -----------------------------------------------------------------------------
// twos_complement_adder
//   Registered WIDTH-bit two's-complement adder with carry-in:
//   sum = x + y + c_in, plus unsigned carry-out and signed-overflow flag.
//   One-cycle latency, one operation per cycle, no stalls.
//
//   Parameters:
//     WIDTH     operand/result width, legal 2..64 (default TCA_DEFAULT_WIDTH)
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset; clears all outputs, beats in_valid
//     in_valid  x/y/c_in carry a new operation this cycle
//     x, y      WIDTH-bit operands
//     c_in      carry-in (weight 1)
//     out_valid sum/c_out/ovf hold a new result this cycle
//     sum       low WIDTH bits of x + y + c_in (clamped when saturating)
//     c_out     raw unsigned carry out of bit WIDTH-1
//     ovf       signed overflow: operands share a sign that the raw sum lost
//
//   Configuration macro TCA_SATURATE_EN:
//     defined   -> on signed overflow sum clamps to 0111..1 (positive operands)
//                  or 1000..0 (negative operands); ovf and c_out unchanged.
//     undefined -> sum is the raw wrapped value; no clamp logic is built.
//
//   Handshake: in_valid is a one-way strobe (there is no ready; the block
//   always accepts). A result appears with out_valid=1 exactly one cycle after
//   the in_valid=1 cycle that produced it. When in_valid=0 the result
//   registers are not loaded, so sum/c_out/ovf hold and unknown operands never
//   reach the registers.
// -----------------------------------------------------------------------------
module twos_complement_adder
  import tca_pkg::*;
#(
  parameter int WIDTH = TCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  // ripple carry chain: carry[0] is c_in, carry[WIDTH] is the carry-out
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] result_sum;
  logic             raw_ovf;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    tca_full_adder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (carry[i]),
      .s    (raw_sum[i]),
      .cout (carry[i+1])
    );
  end

  // Overflow is judged from sign bits only, so it stays independent of the
  // unsigned carry-out.
  assign raw_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (raw_sum[WIDTH-1] != x[WIDTH-1]);

`ifdef TCA_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(tca_signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(tca_signed_min(WIDTH));

  // On overflow both operands share a sign; that sign picks the limit.
  always_comb begin
    result_sum = raw_sum;
    if (raw_ovf) begin
      result_sum = x[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign result_sum = raw_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= result_sum;
        c_out <= carry[WIDTH];
        ovf   <= raw_ovf;
      end
    end
  end

endmodule

// File: tb/tb_twos_complement_adder.sv
// -----------------------------------------------------------------------------
// tb_twos_complement_adder
//   Self-checking bench for twos_complement_adder (WIDTH = 4).
//   Expected results come from integer arithmetic on the operand values; the
//   scoreboard queue holds {c_out, ovf, sum} for each accepted operation.
// -----------------------------------------------------------------------------
module tb_twos_complement_adder;

  localparam int W = 4;
  localparam int MOD = 2 ** W;
  localparam int SMAX = 2 ** (W - 1) - 1;
  localparam int SMIN = -(2 ** (W - 1));

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  twos_complement_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .c_in      (c_in),
    .out_valid (out_valid),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W+1:0] exp_q[$];
  logic [W+1:0] held_exp = '0;   // what sum/c_out/ovf must show right now
  logic         exp_valid = 1'b0;
  int           checks = 0;
  int           failures = 0;

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic logic [W+1:0] ref_model(input int a, input int b, input int c);
    int           total_u;
    int           sa;
    int           sb;
    int           total_s;
    int           s_val;
    logic         cout_b;
    logic         ovf_b;
    logic [W-1:0] s_bits;
    total_u = a + b + c;
    cout_b  = (total_u >= MOD);
    s_val   = total_u % MOD;
    sa      = (a > SMAX) ? a - MOD : a;
    sb      = (b > SMAX) ? b - MOD : b;
    total_s = sa + sb + c;
    ovf_b   = (total_s > SMAX) || (total_s < SMIN);
`ifdef TCA_SATURATE_EN
    if (ovf_b) s_val = (total_s > 0) ? SMAX : (SMIN + MOD);
`endif
    s_bits = W'(s_val);
    return {cout_b, ovf_b, s_bits};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Drives one cycle at the falling edge, then checks outputs 1 ns after the
  // following rising edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input int a, input int b, input int c);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    if (v) begin
      x    = W'(a);
      y    = W'(b);
      c_in = c[0];
    end else begin
      x    = 'x;
      y    = 'x;
      c_in = 1'bx;
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      held_exp  = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      exp_q.push_back(ref_model(a, b, c));
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (exp_valid) held_exp = exp_q.pop_front();
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    check({tag, ".result"}, 64'({c_out, ovf, sum}), 64'(held_exp));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // reset state
    step("reset", 1'b1, 1'b0, 0, 0, 0);
    step("post_reset_idle", 1'b0, 1'b0, 0, 0, 0);

    // directed arithmetic points
    step("add_5_3_c0", 1'b0, 1'b1, 5, 3, 0);
    step("add_5_3_c1", 1'b0, 1'b1, 5, 3, 1);
    step("add_7_2_c1", 1'b0, 1'b1, 7, 2, 1);
    step("wrap_15_1", 1'b0, 1'b1, 15, 1, 0);
    step("neg_8_8", 1'b0, 1'b1, 8, 8, 0);
    step("max_plus_cin", 1'b0, 1'b1, 7, 0, 1);
    step("min_plus_neg1", 1'b0, 1'b1, 8, 15, 0);
    step("all_ones_cin", 1'b0, 1'b1, 15, 15, 1);
    step("zero", 1'b0, 1'b1, 0, 0, 0);
    step("mixed_sign", 1'b0, 1'b1, 8, 7, 1);

    // hold: idle cycles with unknown operands must keep the last result
    step("hold_a", 1'b0, 1'b0, 0, 0, 0);
    step("hold_b", 1'b0, 1'b0, 0, 0, 0);

    // three back-to-back operations, then idle with sum held
    step("stream_0", 1'b0, 1'b1, 3, 4, 0);
    step("stream_1", 1'b0, 1'b1, 9, 12, 1);
    step("stream_2", 1'b0, 1'b1, 6, 6, 0);
    step("stream_idle", 1'b0, 1'b0, 0, 0, 0);

    // reset while a valid operation is presented: nothing survives
    step("pre_rst_op", 1'b0, 1'b1, 2, 3, 0);
    step("rst_with_valid", 1'b1, 1'b1, 7, 7, 1);
    step("after_rst_idle", 1'b0, 1'b0, 0, 0, 0);
    step("after_rst_first", 1'b0, 1'b1, 1, 1, 1);

    // randomized stream with occasional idle cycles
    for (int i = 0; i < 60; i++) begin
      step("random", 1'b0, ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
           int'($urandom_range(0, 1)));
    end

    // random reset hits inside a stream
    for (int i = 0; i < 10; i++) begin
      step("rand_rst", ($urandom_range(0, 4) == 0), 1'b1,
           int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
           int'($urandom_range(0, 1)));
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
